// File: rtl/runner_rng_display_n_if.sv
// runner_rng_display_n_if: control inputs and display outputs of the random-digit display
interface runner_rng_display_n_if #(
  parameter int DIGITS = 3,
  parameter int LFSR_W = 16
);
  logic [1:0] mode;
  logic step;
  logic seed_load;
  logic [LFSR_W-1:0] seed_in;
  logic [7*DIGITS-1:0] seg;
  logic [4*DIGITS-1:0] digits_bcd;
  logic [7:0] leds;
  logic busy;
  logic new_value;
  modport master (
    output mode, step, seed_load, seed_in,
    input seg, digits_bcd, leds, busy, new_value
  );
  modport slave (
    input mode, step, seed_load, seed_in,
    output seg, digits_bcd, leds, busy, new_value
  );
endinterface

// File: rtl/runner_rng_display_n.sv
// runner_rng_display_n: Galois LFSR rejection-sampled into decimal digits, published to active-low seven-segment displays
module runner_rng_display_n #(
  parameter int DIGITS = 3,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
  parameter int DIV_W = 20
) (
  input logic clk,
  input logic rst,
  runner_rng_display_n_if.slave bus
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [LFSR_W-1:0] SEED0 = SEED == '0 ? LFSR_W'(1) : SEED;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_n;
  logic [DIV_W-1:0] div;
  logic [LFSR_W-1:0] lfsr;
  logic [IW-1:0] idx;
  logic [3:0] stage [DIGITS];
  logic [4*DIGITS-1:0] bcd, pub_bcd;
  logic [7*DIGITS-1:0] seg, pub_seg;
  logic nv, start, accept, last, publish;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction
  assign start = (bus.mode == 2'b00 && &div) || (bus.mode == 2'b10 && bus.step);
  assign accept = lfsr[3:0] <= 4'd9;
  assign last = accept && idx == IW'(DIGITS - 1);
  // the final digit is accepted in the same cycle it is published, so bypass staging for it
  for (genvar k = 0; k < DIGITS; k++) begin : g_pub
    assign pub_bcd[4*k +: 4] = idx == IW'(k) ? lfsr[3:0] : stage[k];
    assign pub_seg[7*k +: 7] = seg7(pub_bcd[4*k +: 4]);
  end
  always_comb begin
    publish = state == FILL && last && !bus.seed_load;
    state_n = bus.seed_load ? IDLE : state == IDLE ? (start ? FILL : IDLE) : (last ? IDLE : FILL);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk)
    if (rst) begin
      div <= '0;
      lfsr <= SEED0;
      idx <= '0;
      bcd <= '0;
      seg <= {DIGITS{7'b1000000}};
      nv <= 1'b0;
    end else begin
      div <= div + DIV_W'(1);
      nv <= publish;
      if (bus.seed_load) lfsr <= bus.seed_in == '0 ? LFSR_W'(1) : bus.seed_in;
      else if (state == FILL) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
      idx <= state != FILL ? '0 : idx + IW'(accept);
      if (publish) begin
        bcd <= pub_bcd;
        seg <= pub_seg;
      end
    end
  always_ff @(posedge clk)
    for (int i = 0; i < DIGITS; i++)
      if (state == FILL && accept && idx == IW'(i)) stage[i] <= lfsr[3:0];
  assign bus.seg = seg;
  assign bus.digits_bcd = bcd;
  assign bus.leds = lfsr[7:0];
  assign bus.busy = state == FILL;
  assign bus.new_value = nv;
endmodule

// File: tb/tb_runner_rng_display_n.sv
// tb_runner_rng_display_n: table vectors and directed sequences with a publish scoreboard per instance
module tb_runner_rng_display_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  runner_rng_display_n_if #(.DIGITS(3), .LFSR_W(16)) v0();
  runner_rng_display_n_if #(.DIGITS(1), .LFSR_W(8)) v1();
  runner_rng_display_n_if #(.DIGITS(8), .LFSR_W(8)) v2();

  runner_rng_display_n #(.DIGITS(3), .LFSR_W(16), .TAPS(16'hB400), .SEED(16'hACE1), .DIV_W(4))
    u0 (.clk(clk), .rst(rst), .bus(v0));
  runner_rng_display_n #(.DIGITS(1), .LFSR_W(8), .TAPS(8'hB8), .SEED(8'hB9), .DIV_W(4))
    u1 (.clk(clk), .rst(rst), .bus(v1));
  runner_rng_display_n #(.DIGITS(8), .LFSR_W(8), .TAPS(8'hB8), .SEED(8'hB9), .DIV_W(4))
    u2 (.clk(clk), .rst(rst), .bus(v2));

  typedef struct {
    logic [31:0] bcd;
    int len;
  } exp_t;
  typedef struct {
    logic [15:0] seed;
    logic [31:0] bcd;
    int len;
  } vec_t;

  exp_t q0[$], q1[$], q2[$];
  int tests = 0, fails = 0;
  int nv0 = 0, busy0 = 0, bl0 = 0, bl1 = 0, bl2 = 0;
  logic [31:0] m0, m1, m2;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(logic [3:0] d);
    logic [6:0] t [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return d <= 4'd9 ? t[d] : 7'b1111111;
  endfunction

  function automatic logic [55:0] segs_of(int nd, logic [31:0] bcd);
    logic [55:0] r = '0;
    for (int i = 0; i < nd; i++) r[7*i +: 7] = seg_ref(bcd[4*i +: 4]);
    return r;
  endfunction

  function automatic void model_fill(input int nd, input logic [31:0] taps, inout logic [31:0] l,
                                     output logic [31:0] bcd, output int len);
    int n = 0;
    bcd = '0;
    len = 0;
    while (n < nd) begin
      len++;
      if (l[3:0] <= 4'd9) begin
        bcd[4*n +: 4] = l[3:0];
        n++;
      end
      l = (l >> 1) ^ (l[0] ? taps : 32'h0);
    end
  endfunction

  task automatic pub_check(string name, int nd, exp_t e, logic [31:0] bcd, logic [55:0] seg, int len);
    logic ok = 1'b1;
    for (int i = 0; i < nd; i++) ok &= bcd[4*i +: 4] <= 4'd9;
    chk({name, " digits decimal"}, 64'(ok), 64'(1'b1));
    chk({name, " digits_bcd"}, 64'(bcd), 64'(e.bcd));
    chk({name, " seg"}, 64'(seg), 64'(segs_of(nd, e.bcd)));
    chk({name, " fill length"}, 64'(len), 64'(e.len));
  endtask

  task automatic stray(string name);
    tests++;
    fails++;
    $display("FAIL %s: new_value with empty scoreboard", name);
  endtask

  always @(negedge clk)
    if (rst) bl0 = 0;
    else if (v0.new_value) begin
      nv0++;
      if (q0.size() == 0) stray("u0");
      else pub_check("u0", 3, q0.pop_front(), 32'(v0.digits_bcd), 56'(v0.seg), bl0);
      bl0 = 0;
    end else begin
      if (v0.busy) busy0++;
      bl0 = v0.busy ? bl0 + 1 : 0;
    end

  always @(negedge clk)
    if (rst) bl1 = 0;
    else if (v1.new_value) begin
      if (q1.size() == 0) stray("u1");
      else pub_check("u1", 1, q1.pop_front(), 32'(v1.digits_bcd), 56'(v1.seg), bl1);
      bl1 = 0;
    end else bl1 = v1.busy ? bl1 + 1 : 0;

  always @(negedge clk)
    if (rst) bl2 = 0;
    else if (v2.new_value) begin
      if (q2.size() == 0) stray("u2");
      else pub_check("u2", 8, q2.pop_front(), 32'(v2.digits_bcd), 56'(v2.seg), bl2);
      bl2 = 0;
    end else bl2 = v2.busy ? bl2 + 1 : 0;

  task automatic push0();
    exp_t e;
    model_fill(3, 32'hB400, m0, e.bcd, e.len);
    q0.push_back(e);
  endtask

  task automatic wait_pub(string name, int budget, output int cyc);
    for (cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (v0.new_value) return;
    end
    tests++;
    fails++;
    $display("FAIL %s: no new_value within %0d cycles", name, budget);
  endtask

  task automatic wait_busy(output int first);
    first = 0;
    for (int i = 1; i <= 40 && first == 0; i++) begin
      @(negedge clk);
      if (v0.busy) first = i;
    end
  endtask

  task automatic chk_reset();
    chk("reset seg", 64'(v0.seg), 64'({3{7'b1000000}}));
    chk("reset digits_bcd", 64'(v0.digits_bcd), 64'h0);
    chk("reset leds", 64'(v0.leds), 64'hE1);
    chk("reset busy", 64'(v0.busy), 64'h0);
    chk("reset new_value", 64'(v0.new_value), 64'h0);
  endtask

  initial begin
    vec_t vecs [6];
    exp_t e;
    int cyc, first, n;
    logic [11:0] held_bcd;
    logic [7:0] held_leds;
    vecs = '{'{16'hACE1, 32'h801, 3}, '{16'h000F, 32'h137, 4}, '{16'h0000, 32'h001, 3},
             '{16'h1234, 32'h364, 5}, '{16'h0009, 32'h249, 3}, '{16'h000A, 32'h125, 4}};
    v0.mode = 2'b00; v0.step = 0; v0.seed_load = 0; v0.seed_in = '0;
    v1.mode = 2'b01; v1.step = 0; v1.seed_load = 0; v1.seed_in = '0;
    v2.mode = 2'b01; v2.step = 0; v2.seed_load = 0; v2.seed_in = '0;
    m0 = 32'hACE1; m1 = 32'hB9; m2 = 32'hB9;
    repeat (3) @(negedge clk);
    chk_reset();
    chk("u2 reset leds", 64'(v2.leds), 64'hB9);
    // RUN from reset: first tick, then the ACE1 fill
    push0();
    rst = 0;
    wait_busy(first);
    chk("first fill cycle after reset", 64'(first), 64'd16);
    wait_pub("first publish", 10, cyc);
    chk("busy to new_value", 64'(cyc), 64'd3);
    v0.mode = 2'b01;
    @(negedge clk);
    chk("new_value single pulse", 64'(v0.new_value), 64'h0);
    chk("lfsr after first fill", 64'(v0.leds), 64'h9C);
    // HOLD: ticks and a stray step must not start a fill
    held_bcd = v0.digits_bcd; held_leds = v0.leds; n = nv0; first = busy0;
    repeat (80) @(negedge clk);
    v0.step = 1;
    @(negedge clk);
    v0.step = 0;
    repeat (80) @(negedge clk);
    chk("hold busy cycles", 64'(busy0), 64'(first));
    chk("hold publishes", 64'(nv0), 64'(n));
    chk("hold digits_bcd", 64'(v0.digits_bcd), 64'(held_bcd));
    chk("hold leds", 64'(v0.leds), 64'(held_leds));
    v0.mode = 2'b00;
    push0();
    wait_pub("resume run", 40, cyc);
    chk("resume within one tick", 64'(cyc <= 20), 64'h1);
    v0.mode = 2'b01;
    // STEP vectors; mode drops to HOLD mid-fill and the fill must still finish
    foreach (vecs[i]) begin
      @(negedge clk);
      v0.seed_load = 1; v0.seed_in = vecs[i].seed;
      @(negedge clk);
      v0.seed_load = 0; v0.mode = 2'b10; v0.step = 1;
      e.bcd = vecs[i].bcd; e.len = vecs[i].len;
      q0.push_back(e);
      m0 = vecs[i].seed == 16'h0 ? 32'h1 : 32'(vecs[i].seed);
      model_fill(3, 32'hB400, m0, e.bcd, e.len);
      @(negedge clk);
      v0.step = 0; v0.mode = 2'b01;
      wait_pub($sformatf("vector %0d", i), 60, cyc);
    end
    // seed_load beats a same-cycle start
    @(negedge clk);
    v0.mode = 2'b10; v0.step = 1; v0.seed_load = 1; v0.seed_in = 16'h1234;
    @(negedge clk);
    v0.step = 0; v0.seed_load = 0;
    chk("seed_load over start busy", 64'(v0.busy), 64'h0);
    chk("seed_load over start leds", 64'(v0.leds), 64'h34);
    // abort in the second FILL cycle with a zero seed
    v0.step = 1;
    @(negedge clk);
    v0.step = 0;
    chk("abort fill started", 64'(v0.busy), 64'h1);
    @(negedge clk);
    v0.seed_load = 1; v0.seed_in = 16'h0;
    held_bcd = v0.digits_bcd; n = nv0;
    @(negedge clk);
    v0.seed_load = 0;
    chk("abort busy", 64'(v0.busy), 64'h0);
    chk("abort lfsr coerced", 64'(v0.leds), 64'h01);
    chk("abort display kept", 64'(v0.digits_bcd), 64'(held_bcd));
    @(negedge clk);
    chk("abort no publish", 64'(nv0), 64'(n));
    m0 = 32'h1;
    push0();
    v0.step = 1;
    @(negedge clk);
    v0.step = 0;
    wait_pub("after abort", 60, cyc);
    // reset during FILL
    @(negedge clk);
    v0.step = 1;
    @(negedge clk);
    v0.step = 0;
    chk("pre-reset busy", 64'(v0.busy), 64'h1);
    rst = 1;
    @(negedge clk);
    chk_reset();
    v0.mode = 2'b00;
    m0 = 32'hACE1;
    push0();
    rst = 0;
    wait_busy(first);
    chk("tick restart after reset", 64'(first), 64'd16);
    wait_pub("post-reset publish", 10, cyc);
    v0.mode = 2'b01;
    @(negedge clk);
    // parameter sweep on the 8-bit instances
    v1.mode = 2'b10; v2.mode = 2'b10;
    for (int i = 0; i < 1000; i++) begin
      model_fill(1, 32'hB8, m1, e.bcd, e.len);
      q1.push_back(e);
      model_fill(8, 32'hB8, m2, e.bcd, e.len);
      q2.push_back(e);
      v1.step = 1; v2.step = 1;
      @(negedge clk);
      v1.step = 0; v2.step = 0;
      for (int c = 0; c < 300 && (q1.size() != 0 || q2.size() != 0); c++) @(negedge clk);
      if (q1.size() != 0 || q2.size() != 0) begin
        tests++;
        fails++;
        $display("FAIL sweep publish %0d: pending u1=%0d u2=%0d required 0", i, q1.size(), q2.size());
        break;
      end
    end
    repeat (4) @(negedge clk);
    chk("u0 scoreboard drained", 64'(q0.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule

// File: doc/runner_rng_display_n.md
Name: runner_rng_display_n

Overview:
- Parametrised successor of the runner random-digit display: a Galois LFSR feeds a rejection sampler that produces N uniformly distributed decimal digits (0-9 only), latched and driven as active-low seven-segment codes.
- Adds run/hold/step modes, runtime reseeding, a built-in tick divider, a publish strobe, and a lock-up guard.
- Sits between the board clock and the seven-segment/LED pins.

Parameters:
- DIGITS, 3, number of decimal digits/displays (1..8).
- LFSR_W, 16, LFSR width (8..32).
- TAPS, 16'hB400, Galois feedback mask, width LFSR_W.
- SEED, 16'hACE1, reset value of LFSR; if 0, the value 1 is used instead.
- DIV_W, 20, tick divider width; one tick per 2^DIV_W clocks.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- mode  in  2  00 RUN, 01 HOLD, 10 STEP, 11 treated as HOLD.
- step  in  1  one-cycle request for a new value; used only in STEP mode.
- seed_load  in  1  load seed_in into the LFSR.
- seed_in  in  LFSR_W  new seed.
- seg  out  7*DIGITS  seven-segment codes, active-low, digit k at [7k+6:7k].
- digits_bcd  out  4*DIGITS  published digits, digit k at [4k+3:4k].
- leds  out  8  lfsr[7:0] (diagnostic).
- busy  out  1  high while in FILL.
- new_value  out  1  one-cycle pulse when the display updates.

Behaviour:
- All state is updated on posedge clk. rst is sampled synchronously and has priority over everything.
- Reset values:
  - lfsr = SEED (or 1 if SEED==0).
  - divider = 0; state = IDLE; digit index = 0.
  - digits_bcd = 0; seg = 7'b1000000 for every digit.
  - busy = 0; new_value = 0; leds = SEED[7:0].
- Divider: free-runs in every mode. tick = (divider == all ones), one cycle per 2^DIV_W clocks. First tick occurs 2^DIV_W-1 cycles after reset deasserts.
- LFSR step (Galois, right shift): next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0). The LFSR steps only in FILL, once per cycle.
- Start condition, evaluated in IDLE only:
  - RUN: tick.
  - STEP: step.
  - HOLD/11: never.
  - Ticks and steps arriving while in FILL are ignored, not queued.
- FSM:
  - IDLE: on start, go to FILL at the next edge with index = 0.
  - FILL: each cycle, the candidate is lfsr[3:0] of the current value. If the candidate is <= 9, write it to staging digit[index] and increment index; otherwise reject it (index unchanged). The LFSR steps regardless of accept/reject.
  - On accepting digit DIGITS-1: at the next edge, staging is copied to digits_bcd and seg, new_value = 1 for that one cycle, and state returns to IDLE.
  - Fill duration is data-dependent, with a minimum of DIGITS cycles. busy = (state == FILL).
- Latency (no rejects): start sampled at cycle T; FILL occupies T+1..T+DIGITS; outputs and new_value appear at T+DIGITS+1.
- seed_load:
  - Loads seed_in into the LFSR, or 1 if seed_in == 0.
  - In FILL: aborts the fill, discards partial staging, returns to IDLE; display is unchanged and no new_value is produced.
  - Has priority over a same-cycle start and over an LFSR step.
  - The divider is unaffected.
- Mode change mid-FILL: the fill completes normally. Mode only gates new starts.
- Segment decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other value = 1111111 (unreachable after publish).
- seg and digits_bcd are registered and always mutually consistent.
- Lock-up guard: the LFSR never holds 0 (loads are coerced to 1; Galois stepping from a nonzero state with TAPS[LFSR_W-1]=1 stays nonzero).

Test Plan:
- Reset, defaults, DIV_W=4, RUN -> seg=={3{7'b1000000}}, digits_bcd==0, leds==8'hE1. First tick 15 cycles after reset release. FILL visits lfsr ACE1/E270/7138, accepting 1,0,8 -> digits_bcd==12'h801, seg=={7'b0000000,7'b1000000,7'b1111001}, new_value pulses exactly once, 4 cycles after the tick. LFSR ends at 16'h389C.
- Rejection: seed_load seed_in=16'h000F, STEP, step pulse -> candidate F is rejected (index stays 0, LFSR still steps). Bench model confirms every published digit is <= 9 and fill length equals accepts + rejects.
- HOLD: run 10 ticks -> no busy, no new_value, digits_bcd and leds frozen. Switching to RUN resumes at the next tick.
- Abort: seed_load seed_in=0 in the second FILL cycle -> state IDLE next cycle, lfsr==1, display unchanged, no new_value.
- Mid-operation reset: rst asserted during FILL -> all reset values on the next edge. Tick timing restarts from divider 0.
- Parameter sweep DIGITS=1 and 8, LFSR_W=8 (TAPS=8'hB8, SEED=8'hB9) -> widths correct, 1000 publishes all decimal and matching the reference model.
